cube_points_tx: RTL and testbench

//   AXI-Stream master that emits the 8 projected cube vertices as an 8-beat packet.

---
 rtl/cube_points_tx.sv | 202 ++++++++++++++++++++
 tb/tb_cube_points_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_points_tx.sv
// AXI-Stream master sending the 8 projected cube vertices as one 8-beat packet.
// Vertices land clamped in a shadow bank; a commit snapshots them into the active bank and transmits.
module cube_points_tx #(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CORD_SIZE              = 11,
    parameter int unsigned IN_WIDTH               = 12,
    parameter int unsigned MAX_X                  = 1226,
    parameter int unsigned MAX_Y                  = 370
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic                                  wr_en,
    input  logic [2:0]                            wr_idx,
    input  logic [IN_WIDTH-1:0]                   wr_x,
    input  logic [IN_WIDTH-1:0]                   wr_y,
    input  logic                                  commit,
    output logic                                  busy,
    output logic [7:0]                            commit_drops,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);

    localparam int unsigned TW = C_M00_AXIS_TDATA_WIDTH;
    localparam int unsigned CS = CORD_SIZE;
    localparam int unsigned IW = IN_WIDTH;
    localparam int unsigned NV = 8;
    localparam logic signed [IW:0] X_LIM = (IW+1)'(MAX_X - 1);
    localparam logic signed [IW:0] Y_LIM = (IW+1)'(MAX_Y - 1);

    typedef enum logic {IDLE, SEND} state_t;

    logic          clk;
    logic          rst;
    logic [1:0]    rst_sync;

    state_t        state, state_nxt;
    logic [2:0]    beat, beat_nxt;
    logic [2:0]    beat_inc;
    logic          pending, pending_nxt;
    logic [7:0]    drops_nxt;
    logic          busy_nxt;
    logic          tvalid_nxt, tlast_nxt;
    logic [TW-1:0] tdata_nxt;
    logic          fire;
    logic          load;
    logic          drop_inc;

    logic [CS-1:0] cx, cy;
    logic [CS-1:0] shadow_x [NV];
    logic [CS-1:0] shadow_y [NV];
    logic [CS-1:0] active_x [NV];
    logic [CS-1:0] active_y [NV];
    logic [CS-1:0] snap_x   [NV];
    logic [CS-1:0] snap_y   [NV];

    assign clk            = m00_axis_aclk;
    assign m00_axis_tstrb = '1;
    assign fire           = m00_axis_tvalid & m00_axis_tready;
    assign beat_inc       = beat + 3'd1;

    function automatic logic [CS-1:0] clamp(input logic [IW-1:0] v, input logic signed [IW:0] lim);
        logic signed [IW:0] sv;
        sv = signed'({v[IW-1], v});
        if (sv[IW])
            clamp = '0;
        else if (sv > lim)
            clamp = CS'(lim);
        else
            clamp = CS'(sv);
    endfunction

    function automatic logic [TW-1:0] pack(input logic [CS-1:0] x, input logic [CS-1:0] y);
        pack = TW'({y, x});
    endfunction

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or posedge m00_axis_areset) begin
        if (m00_axis_areset)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    assign cx = clamp(wr_x, X_LIM);
    assign cy = clamp(wr_y, Y_LIM);

    // Snapshot view of the shadow bank with a same-cycle write folded in.
    always_comb begin
        for (int i = 0; i < int'(NV); i++) begin
            snap_x[i] = (wr_en && wr_idx == 3'(i)) ? cx : shadow_x[i];
            snap_y[i] = (wr_en && wr_idx == 3'(i)) ? cy : shadow_y[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NV); i++) begin
                shadow_x[i] <= '0;
                shadow_y[i] <= '0;
                active_x[i] <= '0;
                active_y[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow_x[wr_idx] <= cx;
                shadow_y[wr_idx] <= cy;
            end
            if (load) begin
                for (int i = 0; i < int'(NV); i++) begin
                    active_x[i] <= snap_x[i];
                    active_y[i] <= snap_y[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            beat            <= '0;
            pending         <= 1'b0;
            commit_drops    <= '0;
            busy            <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else begin
            state           <= state_nxt;
            beat            <= beat_nxt;
            pending         <= pending_nxt;
            commit_drops    <= drops_nxt;
            busy            <= busy_nxt;
            m00_axis_tvalid <= tvalid_nxt;
            m00_axis_tlast  <= tlast_nxt;
            m00_axis_tdata  <= tdata_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        pending_nxt = pending;
        drops_nxt   = commit_drops;
        tvalid_nxt  = m00_axis_tvalid;
        tlast_nxt   = m00_axis_tlast;
        tdata_nxt   = m00_axis_tdata;
        load        = 1'b0;
        drop_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt  = SEND;
                    load       = 1'b1;
                    beat_nxt   = '0;
                    tvalid_nxt = 1'b1;
                    tlast_nxt  = 1'b0;
                    tdata_nxt  = pack(snap_x[0], snap_y[0]);
                end
            end
            SEND: begin
                if (fire && beat == 3'd7) begin
                    if (pending || commit) begin
                        // Back-to-back restart; a commit here while pending merges into it.
                        load        = 1'b1;
                        beat_nxt    = '0;
                        tlast_nxt   = 1'b0;
                        tdata_nxt   = pack(snap_x[0], snap_y[0]);
                        pending_nxt = 1'b0;
                        drop_inc    = pending & commit;
                    end else begin
                        state_nxt  = IDLE;
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                    end
                end else begin
                    if (fire) begin
                        beat_nxt  = beat_inc;
                        tlast_nxt = (beat_inc == 3'd7);
                        tdata_nxt = pack(active_x[beat_inc], active_y[beat_inc]);
                    end
                    if (commit) begin
                        if (pending)
                            drop_inc = 1'b1;
                        else
                            pending_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (drop_inc && commit_drops != 8'hFF)
            drops_nxt = commit_drops + 8'd1;
        busy_nxt = (state_nxt == SEND) || pending_nxt;
    end

endmodule

// File: tb/tb_cube_points_tx.sv
// Scoreboard bench for cube_points_tx: expected beats queued at commit, checked on each transfer.
module tb_cube_points_tx;

    localparam int MX = 1226;
    localparam int MY = 370;

    logic        clk = 1'b0;
    logic        areset;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [11:0] wr_x, wr_y;
    logic        commit;
    logic        busy;
    logic [7:0]  commit_drops;
    logic        tready;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb;

    cube_points_tx dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (areset),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .wr_x            (wr_x),
        .wr_y            (wr_y),
        .commit          (commit),
        .busy            (busy),
        .commit_drops    (commit_drops),
        .m00_axis_tready (tready),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tlast  (tlast),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int x;
        int y;
        int ex;
        int ey;
    } vec_t;

    beat_t q[$];
    int    m_x[8];
    int    m_y[8];
    int    checks = 0;
    int    errors = 0;
    int    xfers  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int x, input int y, input bit last);
        beat_t b;
        b.data = (32'(y) << 11) | 32'(x);
        b.last = last;
        q.push_back(b);
    endtask

    task automatic push_packet();
        for (int i = 0; i < 8; i++) push_beat(m_x[i], m_y[i], i == 7);
    endtask

    task automatic write_v(input int idx, input int x, input int y, input bit with_commit);
        wr_en  = 1'b1;
        wr_idx = 3'(idx);
        wr_x   = 12'(x);
        wr_y   = 12'(y);
        commit = with_commit;
        m_x[idx] = clampi(x, MX - 1);
        m_y[idx] = clampi(y, MY - 1);
        tick();
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check(nm, 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        repeat (4) tick();
        q.delete();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
        end
    endtask

    // Transfer monitor plus hold-while-stalled check, sampled mid-cycle.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        beat_t b;
        if (prev_stall && !areset) begin
            check("stall_tvalid", 32'(tvalid), 32'd1);
            check("stall_tdata", tdata, prev_data);
            check("stall_tlast", 32'(tlast), 32'(prev_last));
        end
        if (!areset && tvalid && tready) begin
            xfers++;
            if (q.size() == 0) begin
                check("unexpected_beat", tdata, 32'hFFFF_FFFF);
            end else begin
                b = q.pop_front();
                check("beat_tdata", tdata, b.data);
                check("beat_tlast", 32'(tlast), 32'(b.last));
            end
        end
        prev_stall = !areset && tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   start;

        tbl[0] = '{-5, 400, 0, 369};
        tbl[1] = '{2000, -1, 1225, 0};
        tbl[2] = '{1225, 369, 1225, 369};
        tbl[3] = '{1226, 370, 1225, 369};
        tbl[4] = '{0, 0, 0, 0};
        tbl[5] = '{-2048, 2047, 0, 369};
        tbl[6] = '{-1, -1, 0, 0};
        tbl[7] = '{700, 123, 700, 123};

        areset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0;
        commit = 1'b0; tready = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drops", 32'(commit_drops), 32'd0);
        check("rst_tstrb", 32'(tstrb), 32'hF);
        areset = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
        end
        check("post_rst_busy", 32'(busy), 32'd0);

        // Basic packet: 8 consecutive beats starting one cycle after commit.
        for (int i = 0; i < 8; i++) write_v(i, 100 + i, 50 + i, 1'b0);
        tready = 1'b1;
        push_packet();
        do_commit();
        check("latency_tvalid", 32'(tvalid), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        repeat (8) tick();
        check("basic_done_tvalid", 32'(tvalid), 32'd0);
        check("basic_done_queue", 32'(q.size()), 32'd0);
        check("basic_done_busy", 32'(busy), 32'd0);

        // Clamp table; the last write shares its cycle with the commit.
        for (int i = 0; i < 8; i++) push_beat(tbl[i].ex, tbl[i].ey, i == 7);
        for (int i = 0; i < 7; i++) write_v(i, tbl[i].x, tbl[i].y, 1'b0);
        write_v(7, tbl[7].x, tbl[7].y, 1'b1);
        wait_drain("clamp_drain");
        check("clamp_done_tvalid", 32'(tvalid), 32'd0);

        // Random backpressure over one packet.
        start  = xfers;
        tready = 1'b0;
        push_packet();
        do_commit();
        begin
            int n = 0;
            while (q.size() != 0 && n < 400) begin
                tready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
        end
        check("stall_xfers", 32'(xfers - start), 32'd8);
        check("stall_done_busy", 32'(busy), 32'd0);
        check("stall_done_tvalid", 32'(tvalid), 32'd0);
        tready = 1'b1;

        // Commit at beat 3 with new shadow data: back-to-back, first packet untouched.
        push_packet();
        do_commit();
        repeat (3) tick();
        tready = 1'b0;
        for (int i = 0; i < 8; i++) write_v(i, 600 + 3 * i, 40 * i, 1'b0);
        tready = 1'b1;
        push_packet();
        do_commit();
        repeat (11) tick();
        check("b2b_queue_left", 32'(q.size()), 32'd1);
        tick();
        check("b2b_queue_empty", 32'(q.size()), 32'd0);
        check("b2b_done_tvalid", 32'(tvalid), 32'd0);
        check("b2b_drops", 32'(commit_drops), 32'd0);

        // Three commits during one packet -> one follow-up, two drops.
        do_reset();
        for (int i = 0; i < 8; i++) write_v(i, 10 * i + 5, 300 + i, 1'b0);
        tready = 1'b1;
        push_packet();
        do_commit();
        push_packet();
        repeat (3) do_commit();
        wait_drain("merge3_drain");
        check("merge3_drops", 32'(commit_drops), 32'd2);
        check("merge3_tvalid", 32'(tvalid), 32'd0);
        check("merge3_busy", 32'(busy), 32'd0);

        // Many merged commits saturate the drop counter.
        tready = 1'b0;
        push_packet();
        do_commit();
        push_packet();
        repeat (300) do_commit();
        check("sat_drops", 32'(commit_drops), 32'd255);
        check("sat_busy", 32'(busy), 32'd1);
        tready = 1'b1;
        wait_drain("sat_drain");
        check("sat_done_tvalid", 32'(tvalid), 32'd0);

        // Async reset while stalled on beat 4, then a zeroed packet.
        push_packet();
        do_commit();
        repeat (4) tick();
        tready = 1'b0;
        repeat (2) tick();
        #2;
        areset = 1'b1;
        #1;
        check("async_tvalid", 32'(tvalid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        q.delete();
        for (int i = 0; i < 8; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
        end
        tick();
        tick();
        areset = 1'b0;
        repeat (4) tick();
        check("post_abort_drops", 32'(commit_drops), 32'd0);
        tready = 1'b1;
        push_packet();
        do_commit();
        wait_drain("zero_drain");
        check("zero_done_tvalid", 32'(tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
